alu_operand_collector: RTL and testbench

ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

---
 rtl/alu_operand_collector_if.sv | 54 +++++
 rtl/alu_operand_collector.sv | 169 ++++++++++++++++
 tb/tb_alu_operand_collector.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_collector_if.sv
`default_nettype none
// ============================================================================
// alu_operand_collector_if : command, operand and ALU-side signal bundle
// Rev 1.0
// ============================================================================
interface alu_operand_collector_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic         CMD_VALID;
  logic         CMD_READY;
  logic [M-1:0] CMD_IN;
  logic         MODE_IN;
  logic         CIN_IN;
  logic [1:0]   OPS_IN;

  logic         A_VALID;
  logic         A_READY;
  logic [N-1:0] A_DATA;
  logic         B_VALID;
  logic         B_READY;
  logic [N-1:0] B_DATA;

  logic         ALU_CE;
  logic [1:0]   ALU_INP_VALID;
  logic [N-1:0] ALU_OPA;
  logic [N-1:0] ALU_OPB;
  logic [M-1:0] ALU_CMD;
  logic         ALU_MODE;
  logic         ALU_CIN;

  logic         ISSUED;
  logic         TO_ERR;
  logic         BAD_CMD;
  logic [7:0]   TO_CNT;

  // Producer of commands/operands and consumer of the ALU-side outputs
  modport master (
    output CMD_VALID, CMD_IN, MODE_IN, CIN_IN, OPS_IN,
    output A_VALID, A_DATA, B_VALID, B_DATA,
    input  CMD_READY, A_READY, B_READY,
    input  ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN,
    input  ISSUED, TO_ERR, BAD_CMD, TO_CNT
  );

  modport slave (
    input  CMD_VALID, CMD_IN, MODE_IN, CIN_IN, OPS_IN,
    input  A_VALID, A_DATA, B_VALID, B_DATA,
    output CMD_READY, A_READY, B_READY,
    output ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN,
    output ISSUED, TO_ERR, BAD_CMD, TO_CNT
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_collector.sv
`default_nettype none
// ============================================================================
// alu_operand_collector : gathers a command plus its A/B operands, issues them
// to the ALU in one registered cycle, with timeout and post-issue gap.
// Rev 1.0
// ============================================================================
module alu_operand_collector #(
  parameter int N         = 8,
  parameter int M         = 4,
  parameter int TIMEOUT   = 16,
  parameter int ISSUE_GAP = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  alu_operand_collector_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  localparam int GW = $clog2(ISSUE_GAP + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ISSUE   = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t        r_state;
  logic [1:0]    r_ops;
  logic [1:0]    r_rcv;
  logic [M-1:0]  r_cmd;
  logic          r_mode;
  logic          r_cin;
  logic [N-1:0]  r_opa;
  logic [N-1:0]  r_opb;
  logic [TW-1:0] r_timer;
  logic [GW-1:0] r_gap_cnt;

  logic          r_alu_ce;
  logic [1:0]    r_alu_iv;
  logic [N-1:0]  r_alu_opa;
  logic [N-1:0]  r_alu_opb;
  logic [M-1:0]  r_alu_cmd;
  logic          r_alu_mode;
  logic          r_alu_cin;
  logic          r_issued;
  logic          r_to_err;
  logic          r_bad_cmd;
  logic [7:0]    r_to_cnt;

  logic w_timed_out;
  logic w_cmd_ready;
  logic w_a_ready;
  logic w_b_ready;

  // Once the timer has expired the issue is committed, so no further operands are taken
  assign w_timed_out = (r_timer == TW'(TIMEOUT));
  assign w_cmd_ready = RST && (r_state == S_IDLE);
  assign w_a_ready   = RST && (r_state == S_COLLECT) && r_ops[0] && !r_rcv[0] && !w_timed_out;
  assign w_b_ready   = RST && (r_state == S_COLLECT) && r_ops[1] && !r_rcv[1] && !w_timed_out;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_ops      <= '0;
      r_rcv      <= '0;
      r_cmd      <= '0;
      r_mode     <= 1'b0;
      r_cin      <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_timer    <= '0;
      r_gap_cnt  <= '0;
      r_alu_ce   <= 1'b0;
      r_alu_iv   <= '0;
      r_alu_opa  <= '0;
      r_alu_opb  <= '0;
      r_alu_cmd  <= '0;
      r_alu_mode <= 1'b0;
      r_alu_cin  <= 1'b0;
      r_issued   <= 1'b0;
      r_to_err   <= 1'b0;
      r_bad_cmd  <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_issued  <= 1'b0;
      r_to_err  <= 1'b0;
      r_bad_cmd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.CMD_VALID) begin
            r_cmd  <= bus.CMD_IN;
            r_mode <= bus.MODE_IN;
            r_cin  <= bus.CIN_IN;
            r_ops  <= bus.OPS_IN;
            if (bus.OPS_IN == 2'b00) begin
              r_bad_cmd <= 1'b1;
            end else begin
              r_state <= S_COLLECT;
              r_rcv   <= '0;
              r_timer <= '0;
              r_opa   <= '0;
              r_opb   <= '0;
            end
          end
        end
        S_COLLECT: begin
          // Full mask is tested first so a last operand on the expiry edge wins
          if ((r_rcv == r_ops) || w_timed_out) begin
            r_state    <= S_ISSUE;
            r_alu_ce   <= 1'b1;
            r_alu_iv   <= r_rcv;
            r_alu_opa  <= r_opa;
            r_alu_opb  <= r_opb;
            r_alu_cmd  <= r_cmd;
            r_alu_mode <= r_mode;
            r_alu_cin  <= r_cin;
            r_issued   <= 1'b1;
            if (r_rcv != r_ops) begin
              r_to_err <= 1'b1;
              if (r_to_cnt != 8'hFF) begin
                r_to_cnt <= r_to_cnt + 8'd1;
              end
            end
          end else begin
            if (bus.A_VALID && w_a_ready) begin
              r_rcv[0] <= 1'b1;
              r_opa    <= bus.A_DATA;
            end
            if (bus.B_VALID && w_b_ready) begin
              r_rcv[1] <= 1'b1;
              r_opb    <= bus.B_DATA;
            end
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ISSUE: begin
          r_alu_ce  <= 1'b0;
          r_alu_iv  <= '0;
          r_gap_cnt <= '0;
          r_state   <= (ISSUE_GAP == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(ISSUE_GAP - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.CMD_READY     = w_cmd_ready;
  assign bus.A_READY       = w_a_ready;
  assign bus.B_READY       = w_b_ready;
  assign bus.ALU_CE        = r_alu_ce;
  assign bus.ALU_INP_VALID = r_alu_iv;
  assign bus.ALU_OPA       = r_alu_opa;
  assign bus.ALU_OPB       = r_alu_opb;
  assign bus.ALU_CMD       = r_alu_cmd;
  assign bus.ALU_MODE      = r_alu_mode;
  assign bus.ALU_CIN       = r_alu_cin;
  assign bus.ISSUED        = r_issued;
  assign bus.TO_ERR        = r_to_err;
  assign bus.BAD_CMD       = r_bad_cmd;
  assign bus.TO_CNT        = r_to_cnt;
endmodule
`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
`default_nettype none
// ============================================================================
// tb_alu_operand_collector : directed and randomized checks of the collector
// Rev 1.0
// ============================================================================
module tb_alu_operand_collector;
  localparam int N     = 8;
  localparam int M     = 4;
  localparam int TO    = 16;
  localparam int GAP   = 2;
  localparam int T_OBS = TO + 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_operand_collector_if #(.N(N), .M(M)) bus();

  alu_operand_collector #(.N(N), .M(M), .TIMEOUT(TO), .ISSUE_GAP(GAP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int model_to_cnt = 0;

  // obs_*[t] holds the outputs seen after edge t (edge 0 = command transfer)
  logic         obs_ce[T_OBS];
  logic [1:0]   obs_iv[T_OBS];
  logic [N-1:0] obs_opa[T_OBS];
  logic [N-1:0] obs_opb[T_OBS];
  logic [M-1:0] obs_cmd[T_OBS];
  logic         obs_mode[T_OBS];
  logic         obs_cin[T_OBS];
  logic         obs_issued[T_OBS];
  logic         obs_toerr[T_OBS];
  logic         obs_cready[T_OBS];
  logic [7:0]   obs_tocnt[T_OBS];

  task automatic idle_inputs();
    bus.CMD_VALID = 1'b0; bus.CMD_IN = '0; bus.MODE_IN = 1'b0; bus.CIN_IN = 1'b0; bus.OPS_IN = 2'b00;
    bus.A_VALID = 1'b0; bus.A_DATA = '0; bus.B_VALID = 1'b0; bus.B_DATA = '0;
  endtask

  // Command at edge 0; each operand is offered as a one-cycle VALID pulse at edge da/db
  task automatic run_txn(input logic [M-1:0] cmd, input logic mode, input logic cin,
                         input logic [1:0] ops, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int da, input int db);
    @(negedge CLK);
    bus.CMD_VALID = 1'b1; bus.CMD_IN = cmd; bus.MODE_IN = mode; bus.CIN_IN = cin; bus.OPS_IN = ops;
    bus.A_VALID = (da == 0); bus.A_DATA = (da == 0) ? a : N'($urandom);
    bus.B_VALID = (db == 0); bus.B_DATA = (db == 0) ? b : N'($urandom);
    @(posedge CLK);
    for (int t = 0; t < T_OBS; t++) begin
      @(negedge CLK);
      obs_ce[t] = bus.ALU_CE;   obs_iv[t] = bus.ALU_INP_VALID;
      obs_opa[t] = bus.ALU_OPA; obs_opb[t] = bus.ALU_OPB;
      obs_cmd[t] = bus.ALU_CMD; obs_mode[t] = bus.ALU_MODE; obs_cin[t] = bus.ALU_CIN;
      obs_issued[t] = bus.ISSUED; obs_toerr[t] = bus.TO_ERR;
      obs_cready[t] = bus.CMD_READY; obs_tocnt[t] = bus.TO_CNT;
      bus.CMD_VALID = 1'b0; bus.CMD_IN = M'($urandom); bus.OPS_IN = 2'($urandom);
      bus.MODE_IN = 1'($urandom); bus.CIN_IN = 1'($urandom);
      bus.A_VALID = (da == t + 1); bus.A_DATA = (da == t + 1) ? a : N'($urandom);
      bus.B_VALID = (db == t + 1); bus.B_DATA = (db == t + 1) ? b : N'($urandom);
      if (t < T_OBS - 1) @(posedge CLK);
    end
    bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
  endtask

  // Reference: an operand counts iff required and offered in edges 1..TO; issue follows
  // the completing edge by one, or edge TO+1 on timeout.
  task automatic model_txn(input logic [1:0] ops, input int da, input int db,
                           output logic [1:0] iv, output int ie, output logic to);
    int last;
    iv[0] = ops[0] && (da >= 1) && (da <= TO);
    iv[1] = ops[1] && (db >= 1) && (db <= TO);
    if (iv == ops) begin
      last = 0;
      if (ops[0] && da > last) last = da;
      if (ops[1] && db > last) last = db;
      ie = last + 1;
      to = 1'b0;
    end else begin
      ie = TO + 1;
      to = 1'b1;
    end
    if (to && model_to_cnt < 255) model_to_cnt++;
  endtask

  task automatic test_reset();
    logic [35:0] v;
    idle_inputs();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    v = {bus.ALU_CE, bus.ALU_INP_VALID, bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE,
         bus.ALU_CIN, bus.ISSUED, bus.TO_ERR, bus.BAD_CMD, bus.TO_CNT};
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", v); end
    n_cmp++; if ({bus.CMD_READY, bus.A_READY, bus.B_READY} !== 3'b000) begin
      n_fail++; $display("FAIL reset_readies: got %b want 000", {bus.CMD_READY, bus.A_READY, bus.B_READY}); end
    RST = 1'b1;
    #1;
    n_cmp++; if (bus.CMD_READY !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.CMD_READY); end
    model_to_cnt = 0;
  endtask

  task automatic test_basic();
    int ce_cnt = 0;
    int is_cnt = 0;
    run_txn(4'h0, 1'b1, 1'b0, 2'b11, 8'h0F, 8'h01, 1, 1);
    for (int t = 0; t < T_OBS; t++) begin ce_cnt += int'(obs_ce[t]); is_cnt += int'(obs_issued[t]); end
    n_cmp++; if (obs_ce[2] !== 1'b1) begin n_fail++; $display("FAIL basic_ce_k2: got %b want 1", obs_ce[2]); end
    n_cmp++; if (obs_iv[2] !== 2'b11) begin n_fail++; $display("FAIL basic_iv: got %b want 11", obs_iv[2]); end
    n_cmp++; if ({obs_opa[2], obs_opb[2]} !== 16'h0F01) begin
      n_fail++; $display("FAIL basic_ops: got %h want 0f01", {obs_opa[2], obs_opb[2]}); end
    n_cmp++; if (ce_cnt != 1 || is_cnt != 1) begin
      n_fail++; $display("FAIL basic_pulse_counts: got ce=%0d issued=%0d want 1/1", ce_cnt, is_cnt); end
  endtask

  task automatic test_single_op();
    int fr = -1;
    run_txn(4'h3, 1'b0, 1'b1, 2'b01, 8'hAA, 8'h77, 1, 1);
    for (int t = 0; t < T_OBS; t++) if (fr < 0 && obs_cready[t]) fr = t;
    n_cmp++; if ({obs_ce[2], obs_iv[2], obs_opa[2], obs_opb[2]} !== {1'b1, 2'b01, 8'hAA, 8'h00}) begin
      n_fail++; $display("FAIL single_issue: got ce=%b iv=%b a=%h b=%h want 1 01 aa 00",
                         obs_ce[2], obs_iv[2], obs_opa[2], obs_opb[2]); end
    n_cmp++; if (fr != 2 + GAP + 1) begin n_fail++; $display("FAIL single_cmd_ready_return: got edge %0d want %0d", fr, 2 + GAP + 1); end
  endtask

  task automatic test_bad_cmd();
    @(negedge CLK);
    bus.CMD_VALID = 1'b1; bus.OPS_IN = 2'b00; bus.CMD_IN = 4'h5;
    @(posedge CLK);
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    n_cmp++; if ({bus.BAD_CMD, bus.ALU_CE, bus.CMD_READY} !== 3'b101) begin
      n_fail++; $display("FAIL bad_cmd_pulse: got bad/ce/rdy=%b want 101", {bus.BAD_CMD, bus.ALU_CE, bus.CMD_READY}); end
    @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if ({bus.BAD_CMD, bus.ALU_CE, bus.CMD_READY} !== 3'b001) begin
      n_fail++; $display("FAIL bad_cmd_after: got bad/ce/rdy=%b want 001", {bus.BAD_CMD, bus.ALU_CE, bus.CMD_READY}); end
  endtask

  task automatic test_timeout();
    logic [1:0] iv; int ie; logic to; int te_cnt = 0;
    model_txn(2'b11, 3, 200, iv, ie, to);
    run_txn(4'h1, 1'b0, 1'b0, 2'b11, 8'h3C, 8'hC3, 3, 200);
    for (int t = 0; t < T_OBS; t++) te_cnt += int'(obs_toerr[t]);
    n_cmp++; if ({obs_ce[ie], obs_toerr[ie], obs_iv[ie]} !== {1'b1, 1'b1, 2'b01}) begin
      n_fail++; $display("FAIL timeout_issue: got ce/to/iv=%b want 1101 at edge %0d", {obs_ce[ie], obs_toerr[ie], obs_iv[ie]}, ie); end
    n_cmp++; if (te_cnt != 1) begin n_fail++; $display("FAIL timeout_pulse_count: got %0d want 1", te_cnt); end
    n_cmp++; if (obs_tocnt[ie] !== 8'(model_to_cnt)) begin
      n_fail++; $display("FAIL timeout_to_cnt: got %0d want %0d", obs_tocnt[ie], model_to_cnt); end
  endtask

  task automatic test_expiry_edge();
    logic [1:0] iv; int ie; logic to; int te_cnt = 0;
    model_txn(2'b11, 2, TO, iv, ie, to);
    run_txn(4'h2, 1'b1, 1'b1, 2'b11, 8'h11, 8'h99, 2, TO);
    for (int t = 0; t < T_OBS; t++) te_cnt += int'(obs_toerr[t]);
    n_cmp++; if ({obs_ce[ie], obs_iv[ie], obs_opb[ie]} !== {1'b1, 2'b11, 8'h99}) begin
      n_fail++; $display("FAIL expiry_issue: got ce=%b iv=%b b=%h want 1 11 99", obs_ce[ie], obs_iv[ie], obs_opb[ie]); end
    n_cmp++; if (te_cnt != 0) begin n_fail++; $display("FAIL expiry_to_err: got %0d pulses want 0", te_cnt); end
    n_cmp++; if (obs_tocnt[ie] !== 8'(model_to_cnt)) begin
      n_fail++; $display("FAIL expiry_to_cnt: got %0d want %0d", obs_tocnt[ie], model_to_cnt); end
  endtask

  task automatic test_random(input int n);
    logic [M-1:0] cmd; logic mode, cin; logic [1:0] ops; logic [N-1:0] a, b;
    int da, db, ie, ce_cnt, fr; logic [1:0] iv; logic to;
    for (int i = 0; i < n; i++) begin
      cmd = M'($urandom); mode = 1'($urandom); cin = 1'($urandom);
      ops = 2'($urandom_range(1, 3)); a = N'($urandom); b = N'($urandom);
      da = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 3)) : int'($urandom_range(0, 6));
      db = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 3)) : int'($urandom_range(0, 6));
      model_txn(ops, da, db, iv, ie, to);
      run_txn(cmd, mode, cin, ops, a, b, da, db);
      ce_cnt = 0; fr = -1;
      for (int t = 0; t < T_OBS; t++) begin
        ce_cnt += int'(obs_ce[t]);
        if (fr < 0 && obs_cready[t]) fr = t;
      end
      n_cmp++; if (obs_ce[ie] !== 1'b1 || ce_cnt != 1) begin
        n_fail++; $display("FAIL rand_ce[%0d]: got ce@%0d=%b count=%0d want 1/1 (ops=%b da=%0d db=%0d)", i, ie, obs_ce[ie], ce_cnt, ops, da, db); end
      n_cmp++; if ({obs_iv[ie], obs_opa[ie], obs_opb[ie]} !== {iv, (iv[0] ? a : 8'h00), (iv[1] ? b : 8'h00)}) begin
        n_fail++; $display("FAIL rand_data[%0d]: got iv=%b a=%h b=%h want iv=%b a=%h b=%h", i, obs_iv[ie], obs_opa[ie], obs_opb[ie],
                           iv, (iv[0] ? a : 8'h00), (iv[1] ? b : 8'h00)); end
      n_cmp++; if ({obs_cmd[ie], obs_mode[ie], obs_cin[ie]} !== {cmd, mode, cin}) begin
        n_fail++; $display("FAIL rand_cmd[%0d]: got %h want %h", i, {obs_cmd[ie], obs_mode[ie], obs_cin[ie]}, {cmd, mode, cin}); end
      n_cmp++; if ({obs_issued[ie], obs_toerr[ie], obs_tocnt[ie]} !== {1'b1, to, 8'(model_to_cnt)}) begin
        n_fail++; $display("FAIL rand_status[%0d]: got iss=%b to=%b cnt=%0d want 1 %b %0d", i, obs_issued[ie], obs_toerr[ie], obs_tocnt[ie], to, model_to_cnt); end
      n_cmp++; if ({obs_iv[ie+1], obs_opa[ie+1], obs_opb[ie+1]} !== {2'b00, obs_opa[ie], obs_opb[ie]} ||
                   {obs_opa[ie], obs_opb[ie]} !== {(iv[0] ? a : 8'h00), (iv[1] ? b : 8'h00)}) begin
        n_fail++; $display("FAIL rand_gap_hold[%0d]: got iv=%b a=%h b=%h", i, obs_iv[ie+1], obs_opa[ie+1], obs_opb[ie+1]); end
      n_cmp++; if (fr != ie + GAP + 1) begin
        n_fail++; $display("FAIL rand_cmd_ready[%0d]: got first ready edge %0d want %0d", i, fr, ie + GAP + 1); end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] v; int bad_pulses = 0;
    @(negedge CLK);
    bus.CMD_VALID = 1'b1; bus.OPS_IN = 2'b11; bus.CMD_IN = 4'h7;
    @(posedge CLK);
    @(negedge CLK);
    bus.CMD_VALID = 1'b0; bus.A_VALID = 1'b1; bus.A_DATA = 8'h5A;
    @(posedge CLK);
    @(negedge CLK);
    bus.A_VALID = 1'b0; bus.B_VALID = 1'b1; bus.B_DATA = 8'hE1;
    RST = 1'b0;
    #1;
    n_cmp++; if ({bus.CMD_READY, bus.A_READY, bus.B_READY} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_readies: got %b want 000", {bus.CMD_READY, bus.A_READY, bus.B_READY}); end
    @(posedge CLK);
    @(negedge CLK);
    v = {bus.ALU_CE, bus.ALU_INP_VALID, bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE,
         bus.ALU_CIN, bus.ISSUED, bus.TO_ERR, bus.BAD_CMD, bus.TO_CNT};
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h want 0", v); end
    bus.B_VALID = 1'b0;
    RST = 1'b1;
    model_to_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge CLK);
      bad_pulses += int'(bus.ISSUED) + int'(bus.TO_ERR);
    end
    n_cmp++; if (bad_pulses != 0) begin n_fail++; $display("FAIL midrst_stale_pulses: got %0d want 0", bad_pulses); end
    run_txn(4'h9, 1'b0, 1'b0, 2'b10, 8'h44, 8'hC3, 2, 1);
    n_cmp++; if ({obs_ce[2], obs_iv[2], obs_opa[2], obs_opb[2]} !== {1'b1, 2'b10, 8'h00, 8'hC3}) begin
      n_fail++; $display("FAIL midrst_fresh: got ce=%b iv=%b a=%h b=%h want 1 10 00 c3", obs_ce[2], obs_iv[2], obs_opa[2], obs_opb[2]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_op();
    test_bad_cmd();
    test_timeout();
    test_expiry_edge();
    test_random(40);
    test_reset_mid();
    test_random(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
